// File: rtl/hybrid_pkg.sv
// Shared constants, FSM state type and bin-order helper for the hybrid
// result serializer. The macro HYBRID_SER_BITREV_EN (consumed only in
// hybrid_idx_map) selects bit-reversed bin order; undefined means natural order.
package hybrid_pkg;

    localparam int N_PTS       = 8;
    localparam int IDX_W       = 3;
    localparam int DEF_DATA_W  = 12;
    localparam int FRAME_CNT_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    // Mirror the bits of an index so bit 0 becomes the MSB
    function automatic logic [IDX_W-1:0] bit_reverse(input logic [IDX_W-1:0] v);
        logic [IDX_W-1:0] r;
        for (int i = 0; i < IDX_W; i++) begin
            r[i] = v[IDX_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/hybrid_idx_map.sv
// Beat-to-bin mapping for the serializer. This is the only logic that
// depends on HYBRID_SER_BITREV_EN: defined gives order 0,4,2,6,1,5,3,7,
// undefined gives natural order 0..7.
module hybrid_idx_map
    import hybrid_pkg::*;
(
    input  logic [IDX_W-1:0] beat,
    output logic [IDX_W-1:0] idx
);

    // Translate the running beat number into the bin index to present
    always_comb begin
`ifdef HYBRID_SER_BITREV_EN
        idx = bit_reverse(beat);
`else
        idx = beat;
`endif
    end

endmodule

// File: rtl/hybrid_result_serializer.sv
// Hybrid result serializer: captures a full 8-bin complex transform result
// in one cycle and streams it out one bin per accepted beat over a
// valid/ready interface. Bin order is chosen by HYBRID_SER_BITREV_EN
// (see hybrid_idx_map). A new frame can be taken on the same edge that the
// last beat of the current frame leaves, so frames can flow back to back.
module hybrid_result_serializer
    import hybrid_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   CLK,
    input  logic                   RESET,
    input  logic                   frame_valid,
    input  logic [DATA_W-1:0]      rI0,
    input  logic [DATA_W-1:0]      rI1,
    input  logic [DATA_W-1:0]      rI2,
    input  logic [DATA_W-1:0]      rI3,
    input  logic [DATA_W-1:0]      rI4,
    input  logic [DATA_W-1:0]      rI5,
    input  logic [DATA_W-1:0]      rI6,
    input  logic [DATA_W-1:0]      rI7,
    input  logic [DATA_W-1:0]      iI0,
    input  logic [DATA_W-1:0]      iI1,
    input  logic [DATA_W-1:0]      iI2,
    input  logic [DATA_W-1:0]      iI3,
    input  logic [DATA_W-1:0]      iI4,
    input  logic [DATA_W-1:0]      iI5,
    input  logic [DATA_W-1:0]      iI6,
    input  logic [DATA_W-1:0]      iI7,
    output logic                   frame_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [DATA_W-1:0]      out_re,
    output logic [DATA_W-1:0]      out_im,
    output logic [IDX_W-1:0]       out_idx,
    output logic                   out_last,
    output logic [FRAME_CNT_W-1:0] frames_sent
);

    state_t                 state;
    state_t                 state_next;
    logic [IDX_W-1:0]       beat;
    logic [IDX_W-1:0]       map_idx;
    logic [DATA_W-1:0]      buf_re [N_PTS];
    logic [DATA_W-1:0]      buf_im [N_PTS];
    logic [DATA_W-1:0]      in_re  [N_PTS];
    logic [DATA_W-1:0]      in_im  [N_PTS];
    logic                   accept;
    logic                   xfer;
    logic                   frame_done;
    logic [FRAME_CNT_W-1:0] sent_count;

    // Gather the flat bin ports into arrays so capture can be a simple loop
    always_comb begin
        in_re[0] = rI0;
        in_re[1] = rI1;
        in_re[2] = rI2;
        in_re[3] = rI3;
        in_re[4] = rI4;
        in_re[5] = rI5;
        in_re[6] = rI6;
        in_re[7] = rI7;
        in_im[0] = iI0;
        in_im[1] = iI1;
        in_im[2] = iI2;
        in_im[3] = iI3;
        in_im[4] = iI4;
        in_im[5] = iI5;
        in_im[6] = iI6;
        in_im[7] = iI7;
    end

    hybrid_idx_map u_idx_map (
        .beat (beat),
        .idx  (map_idx)
    );

    assign out_last   = (beat == IDX_W'(N_PTS - 1));
    assign accept     = frame_valid && frame_ready;
    assign xfer       = out_valid && out_ready;
    assign frame_done = xfer && out_last;

    // State register; reset drops any frame in flight
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and handshake outputs; ready reopens during the final beat
    always_comb begin
        state_next  = state;
        frame_ready = 1'b0;
        out_valid   = 1'b0;
        case (state)
            ST_IDLE: begin
                frame_ready = 1'b1;
                if (frame_valid) begin
                    state_next = ST_SEND;
                end
            end
            ST_SEND: begin
                out_valid = 1'b1;
                if (out_ready && out_last) begin
                    frame_ready = 1'b1;
                    state_next  = frame_valid ? ST_SEND : ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Sample buffer: loaded whole on acceptance, cleared by reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int i = 0; i < N_PTS; i++) begin
                buf_re[i] <= '0;
                buf_im[i] <= '0;
            end
        end else if (accept) begin
            for (int i = 0; i < N_PTS; i++) begin
                buf_re[i] <= in_re[i];
                buf_im[i] <= in_im[i];
            end
        end
    end

    // Beat counter; a new frame always restarts at beat 0
    always_ff @(posedge CLK) begin
        if (RESET) begin
            beat <= '0;
        end else if (accept) begin
            beat <= '0;
        end else if (xfer) begin
            beat <= beat + 1'b1;
        end
    end

    // Completed-frame counter, wrapping naturally at its width
    always_ff @(posedge CLK) begin
        if (RESET) begin
            sent_count <= '0;
        end else if (frame_done) begin
            sent_count <= sent_count + 1'b1;
        end
    end

    assign out_re      = buf_re[map_idx];
    assign out_im      = buf_im[map_idx];
    assign out_idx     = map_idx;
    assign frames_sent = sent_count;

endmodule

// File: tb/tb_hybrid_result_serializer.sv
// Self-checking bench for hybrid_result_serializer. A queue-based model of
// the sample stream predicts every output; directed tables and sequences
// cover ordering, backpressure, back-to-back frames, reset and counter wrap.
module tb_hybrid_result_serializer;

    localparam int DW = 12;

    typedef struct {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    idx;
        logic          last;
    } samp_t;

    typedef struct {
        logic          rdy;
        logic [DW-1:0] re;
        logic [DW-1:0] im;
        logic [2:0]    idx;
        logic          last;
    } vec_t;

    logic          CLK = 1'b0;
    logic          RESET;
    logic          frame_valid;
    logic          out_ready;
    logic [DW-1:0] f_re [8];
    logic [DW-1:0] f_im [8];
    logic          frame_ready;
    logic          out_valid;
    logic [DW-1:0] out_re;
    logic [DW-1:0] out_im;
    logic [2:0]    out_idx;
    logic          out_last;
    logic [15:0]   frames_sent;

    int          total = 0;
    int          bad = 0;
    samp_t       q[$];
    logic [15:0] m_count = '0;
    bit          checking = 1'b0;
    bit          just_reset = 1'b0;
    bit          took_frame = 1'b0;

    hybrid_result_serializer #(.DATA_W(DW)) dut (
        .CLK         (CLK),
        .RESET       (RESET),
        .frame_valid (frame_valid),
        .rI0 (f_re[0]), .rI1 (f_re[1]), .rI2 (f_re[2]), .rI3 (f_re[3]),
        .rI4 (f_re[4]), .rI5 (f_re[5]), .rI6 (f_re[6]), .rI7 (f_re[7]),
        .iI0 (f_im[0]), .iI1 (f_im[1]), .iI2 (f_im[2]), .iI3 (f_im[3]),
        .iI4 (f_im[4]), .iI5 (f_im[5]), .iI6 (f_im[6]), .iI7 (f_im[7]),
        .frame_ready (frame_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_re      (out_re),
        .out_im      (out_im),
        .out_idx     (out_idx),
        .out_last    (out_last),
        .frames_sent (frames_sent)
    );

    // Free-running clock, period 10
    always #5 CLK = ~CLK;

    // Position in the frame -> bin index sent at that position
    function automatic logic [2:0] bin_of(input int b);
        logic [2:0] v;
        v = b[2:0];
`ifdef HYBRID_SER_BITREV_EN
        return {v[0], v[1], v[2]};
`else
        return v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit expReady();
        return (q.size() == 0) || (q.size() == 1 && out_ready);
    endfunction

    task automatic checkOutput();
        if (!checking) return;
        check("out_valid", 32'(out_valid), 32'(q.size() > 0));
        check("frame_ready", 32'(frame_ready), 32'(expReady()));
        check("frames_sent", 32'(frames_sent), 32'(m_count));
        if (q.size() > 0) begin
            check("out_re", 32'(out_re), 32'(q[0].re));
            check("out_im", 32'(out_im), 32'(q[0].im));
            check("out_idx", 32'(out_idx), 32'(q[0].idx));
            check("out_last", 32'(out_last), 32'(q[0].last));
        end
        if (just_reset) begin
            check("rst_out_re", 32'(out_re), 32'd0);
            check("rst_out_im", 32'(out_im), 32'd0);
            check("rst_out_idx", 32'(out_idx), 32'd0);
            check("rst_out_last", 32'(out_last), 32'd0);
        end
    endtask

    // Advance the model by the edge about to happen, using current inputs
    task automatic modelStep();
        bit rdy;
        bit vld;
        took_frame = 1'b0;
        if (RESET) begin
            q.delete();
            m_count    = '0;
            just_reset = 1'b1;
            checking   = 1'b1;
            return;
        end
        just_reset = 1'b0;
        rdy = expReady();
        vld = (q.size() > 0);
        if (vld && out_ready) begin
            if (q[0].last) m_count = m_count + 16'd1;
            void'(q.pop_front());
        end
        if (frame_valid && rdy) begin
            took_frame = 1'b1;
            for (int b = 0; b < 8; b++) begin
                samp_t s;
                s.idx  = bin_of(b);
                s.re   = f_re[s.idx];
                s.im   = f_im[s.idx];
                s.last = (b == 7);
                q.push_back(s);
            end
        end
    endtask

    // One clock: check settled outputs, update model, go to next negedge
    task automatic cycle();
        #1;
        checkOutput();
        modelStep();
        @(negedge CLK);
    endtask

    task automatic applyStimulus(input logic fv, input logic rdy);
        frame_valid = fv;
        out_ready   = rdy;
        cycle();
    endtask

    task automatic loadRandom();
        for (int k = 0; k < 8; k++) begin
            f_re[k] = DW'($urandom);
            f_im[k] = DW'($urandom);
        end
    endtask

    vec_t tbl [8];
    int   exp_idx [8];
    int   exp_re [8];

    initial begin
        int v;
`ifdef HYBRID_SER_BITREV_EN
        exp_idx = '{0, 4, 2, 6, 1, 5, 3, 7};
        exp_re  = '{10, 6, 8, 4, 9, 5, 7, 3};
`else
        exp_idx = '{0, 1, 2, 3, 4, 5, 6, 7};
        exp_re  = '{10, 9, 8, 7, 6, 5, 4, 3};
`endif
        for (int k = 0; k < 8; k++) begin
            tbl[k].rdy  = 1'b1;
            tbl[k].re   = DW'(exp_re[k]);
            tbl[k].im   = DW'(exp_idx[k]);
            tbl[k].idx  = 3'(exp_idx[k]);
            tbl[k].last = (k == 7);
        end

        RESET = 1'b1;
        frame_valid = 1'b0;
        out_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            f_re[k] = '0;
            f_im[k] = '0;
        end
        @(negedge CLK);
        cycle();
        cycle();
        RESET = 1'b0;

        // Reset then idle
        #1;
        check("idle_valid", 32'(out_valid), 32'd0);
        check("idle_ready", 32'(frame_ready), 32'd1);
        check("idle_count", 32'(frames_sent), 32'd0);
        applyStimulus(1'b0, 1'b1);

        // Known frame streamed with out_ready held high
        for (int k = 0; k < 8; k++) begin
            f_re[k] = DW'(10 - k);
            f_im[k] = DW'(k);
        end
        applyStimulus(1'b1, 1'b1);
        frame_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            out_ready = tbl[k].rdy;
            #1;
            check("tbl_valid", 32'(out_valid), 32'd1);
            check("tbl_re", 32'(out_re), 32'(tbl[k].re));
            check("tbl_im", 32'(out_im), 32'(tbl[k].im));
            check("tbl_idx", 32'(out_idx), 32'(tbl[k].idx));
            check("tbl_last", 32'(out_last), 32'(tbl[k].last));
            cycle();
        end
        #1;
        check("tbl_count", 32'(frames_sent), 32'd1);
        check("tbl_done_valid", 32'(out_valid), 32'd0);
        applyStimulus(1'b0, 1'b1);

        // Three stalled cycles while beat 2 is presented
        loadRandom();
        applyStimulus(1'b1, 1'b1);
        frame_valid = 1'b0;
        for (int c = 0; c < 11; c++) begin
            out_ready = !(c >= 2 && c < 5);
            #1;
            if (c >= 2 && c <= 5) begin
                check("stall_idx", 32'(out_idx), 32'(bin_of(2)));
                check("stall_re", 32'(out_re), 32'(f_re[bin_of(2)]));
            end
            cycle();
        end
        #1;
        check("stall_count", 32'(frames_sent), 32'd2);
        applyStimulus(1'b0, 1'b1);

        // Two frames back to back with frame_valid held high
        loadRandom();
        applyStimulus(1'b1, 1'b1);
        loadRandom();
        v = 0;
        for (int i = 0; i < 16; i++) begin
            if (i == 8) frame_valid = 1'b0;
            #1;
            if (out_valid) v++;
            cycle();
        end
        #1;
        check("b2b_beats", 32'(v), 32'd16);
        check("b2b_count", 32'(frames_sent), 32'd4);
        applyStimulus(1'b0, 1'b1);

        // Reset while beat 4 is presented
        loadRandom();
        applyStimulus(1'b1, 1'b1);
        frame_valid = 1'b0;
        for (int i = 0; i < 4; i++) cycle();
        RESET = 1'b1;
        cycle();
        RESET = 1'b0;
        #1;
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(frames_sent), 32'd0);
        applyStimulus(1'b0, 1'b1);

        // Counter wrap from 0xFFFF
        force dut.sent_count = 16'hFFFF;
        m_count = 16'hFFFF;
        cycle();
        release dut.sent_count;
        cycle();
        loadRandom();
        applyStimulus(1'b1, 1'b1);
        frame_valid = 1'b0;
        for (int i = 0; i < 8; i++) cycle();
        #1;
        check("wrap_count", 32'(frames_sent), 32'd0);
        applyStimulus(1'b0, 1'b1);

        // Random traffic; upstream holds its frame until it is taken
        frame_valid = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!frame_valid || took_frame) begin
                frame_valid = ($urandom_range(0, 2) != 0);
                loadRandom();
            end
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        frame_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 12; c++) cycle();
        #1;
        check("drain_valid", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hybrid_result_serializer.md
HYBRID_RESULT_SERIALIZER -- requirements
Module: hybrid_result_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter DATA_W, default 12, SHALL set the width of each real and imaginary sample.
REQ-003 CLK  input  1  SHALL be the single clock; all state SHALL update on the rising edge.
REQ-004 RESET  input  1  SHALL be the synchronous, active-high reset.
REQ-005 frame_valid  input  1  SHALL indicate that a complete 8-point transform result is present on rI*/iI*.
REQ-006 rI0..rI7  input  DATA_W each  SHALL carry the real parts of transform bins 0..7.
REQ-007 iI0..iI7  input  DATA_W each  SHALL carry the imaginary parts of transform bins 0..7.
REQ-008 frame_ready  output  1  SHALL indicate that the block accepts a frame this cycle.
REQ-009 out_valid  output  1  SHALL indicate that a sample is presented.
REQ-010 out_ready  input  1  SHALL be asserted by the downstream consumer to accept a sample.
REQ-011 out_re, out_im  output  DATA_W each  SHALL carry the presented bin's real and imaginary parts.
REQ-012 out_idx  output  3  SHALL carry the bin index of the presented sample.
REQ-013 out_last  output  1  SHALL be high on the 8th sample of a frame.
REQ-014 frames_sent  output  16  SHALL count completed frames and wrap modulo 2^16.

Function
REQ-015 The FSM SHALL have two states:
- IDLE: no frame held.
- SEND: frame held; samples are presented.
REQ-016 A frame SHALL be accepted on a rising edge where frame_valid && frame_ready; all 16 inputs SHALL be captured into an internal 8x2xDATA_W buffer, and the FSM SHALL enter SEND with beat counter = 0.
REQ-017 frame_ready SHALL be combinational.
- It SHALL be high in IDLE.
- In SEND it SHALL be high only while out_valid && out_ready && out_last (back-to-back acceptance).
REQ-018 out_valid SHALL be high exactly when the FSM is in SEND.
- First sample SHALL appear the cycle after acceptance (latency 1).
REQ-019 A sample SHALL be transferred on each edge where out_valid && out_ready; the beat counter SHALL then increment.
REQ-020 While out_valid && !out_ready, out_re, out_im, out_idx and out_last SHALL hold stable.
REQ-021 The frame-complete case SHALL apply when beat 7 is transferred:
- frames_sent SHALL increment, with 0xFFFF wrapping to 0x0000.
- If a new frame is accepted on the same edge, the FSM SHALL stay in SEND with beat = 0 and the new data.
- Otherwise the FSM SHALL return to IDLE.
REQ-022 frame_valid while frame_ready is low SHALL be ignored; the upstream holds its data.
REQ-023 out_idx SHALL equal map(beat), where map is defined in REQ-027.
- out_re/out_im SHALL be buffer entry map(beat).
- out_last SHALL equal (beat == 7).
REQ-024 Samples SHALL pass through unmodified; no arithmetic or sign handling is applied.

Reset
REQ-025 When RESET is high at a clock edge, the block SHALL enter the following state regardless of any transfer in progress:
- FSM = IDLE, beat = 0, frames_sent = 0, buffer cleared.
- out_valid = 0, out_re = out_im = 0, out_idx = 0, out_last = 0.
- frame_ready SHALL be 1 from the first cycle after reset.
REQ-026 A frame partly sent when reset is asserted SHALL be discarded and SHALL NOT be counted.

Configuration
REQ-027 The macro HYBRID_SER_BITREV_EN SHALL select the output bin order:
- Defined: map(beat) = 3-bit reversal of beat, giving order 0,4,2,6,1,5,3,7.
- Undefined: map(beat) = beat, giving natural order 0..7.

Structure
REQ-028 Package hybrid_pkg SHALL hold N_PTS = 8, IDX_W = 3, the default DATA_W = 12 and the FSM state enum.
REQ-029 The index mapping SHALL be a combinational sub-module hybrid_idx_map; it is the only macro-dependent logic.

Verification
REQ-030 Reset then idle: after RESET, out_valid = 0, frame_ready = 1, frames_sent = 0.
REQ-031 Natural order: frame rI = 10,9,8,7,6,5,4,3 and iI = 0..7 with out_ready = 1 -> 8 consecutive beats.
- out_re = 10..3, out_idx = 0..7, out_last only on beat 8, frames_sent = 1.
REQ-032 Bit-reversed order: same frame with HYBRID_SER_BITREV_EN -> out_idx = 0,4,2,6,1,5,3,7 and out_re = 10,6,8,4,9,5,7,3.
REQ-033 Backpressure: out_ready low for 3 cycles at beat 2 -> outputs hold; then all 8 beats complete with none lost or duplicated.
REQ-034 Back-to-back: frame_valid held high across two frames -> second frame accepted on the last-beat edge with no idle cycle; 16 contiguous beats; frames_sent = 2.
REQ-035 Mid-frame reset and wrap: RESET at beat 4 -> out_valid = 0 next cycle, frames_sent = 0; separately, frames_sent preloaded 0xFFFF then one frame -> 0x0000.
